// File: rtl/clint_mh_pkg.sv
// Shared constants, register selectors and address decoder for the multi-hart CLINT.
package clint_mh_pkg;

    localparam logic        RESET_ENABLE = 1'b1;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic [31:0] ZERO         = 32'h0;

    localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_ADDR    = 16'hBFF8;
    localparam int          MSIP_STRIDE         = 4;
    localparam int          MTIMECMP_STRIDE     = 8;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [3:0] hart;
    } decode_t;

    // Relative offsets wrap below their base, so one unsigned compare bounds each window.
    function automatic decode_t decode_addr(input logic [15:0] off, input int num_harts);
        decode_t     d;
        logic [15:0] rel_msip;
        logic [15:0] rel_cmp;
        d.sel    = REG_NONE;
        d.hart   = 4'd0;
        rel_msip = off - CLINT_MSIP_BASE;
        rel_cmp  = off - CLINT_MTIMECMP_BASE;
        if (off[1:0] == 2'b00) begin
            if (off == CLINT_MTIME_ADDR) begin
                d.sel = REG_MTIME_LO;
            end else if (off == CLINT_MTIME_ADDR + 16'd4) begin
                d.sel = REG_MTIME_HI;
            end else if (rel_cmp < 16'(MTIMECMP_STRIDE * num_harts)) begin
                d.hart = 4'(rel_cmp / 16'(MTIMECMP_STRIDE));
                d.sel  = rel_cmp[2] ? REG_CMP_HI : REG_CMP_LO;
            end else if (rel_msip < 16'(MSIP_STRIDE * num_harts)) begin
                d.hart = 4'(rel_msip / 16'(MSIP_STRIDE));
                d.sel  = REG_MSIP;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/clint_mh_if.sv
// Data-bus port of the CLINT: single-cycle request, registered read response.
interface clint_mh_if #(
    parameter int DATA_WIDTH = 32
);
    // There is no ready: every req_i cycle is accepted. Writes (we_i=1) complete at the
    // clock edge with no response; a read raises rvalid_o with data_o for exactly the
    // following cycle, and back-to-back reads stream one result per cycle.
    logic                  req_i;
    logic                  we_i;
    logic [DATA_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  rvalid_o;

    modport master (
        output req_i, we_i, addr_i, data_i,
        input  data_o, rvalid_o
    );

    modport slave (
        input  req_i, we_i, addr_i, data_i,
        output data_o, rvalid_o
    );
endinterface

// File: rtl/clint_mh_mtime.sv
// Shared mtime counter: prescaler, 64-bit increment, per-half bus write and debug stop.
module clint_mh_mtime
    import clint_mh_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stop_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] mtime_o
);

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic        tick;

    always_comb begin
        tick    = ~stop_i && (presc_q == PRESC_MAX);
        presc_d = presc_q;
        mtime_d = mtime_q;
        if (!stop_i) begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
        end
        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        // A write replaces the whole update: the untouched half keeps its old value.
        if (wr_lo_i) begin
            mtime_d = {mtime_q[63:32], wdata_i};
        end else if (wr_hi_i) begin
            mtime_d = {wdata_i, mtime_q[31:0]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i == RESET_ENABLE) begin
            presc_q <= 16'd0;
            mtime_q <= 64'd0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: shared mtime, per-hart msip and mtimecmp on a bus slave.
module clint_mh
    import clint_mh_pkg::*;
#(
    parameter int NUM_HARTS  = 2,
    parameter int TICK_DIV   = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    clint_mh_if.slave            bus,
    input  logic                 mtime_stop_i,
    output logic [NUM_HARTS-1:0] timer_irq_o,
    output logic [NUM_HARTS-1:0] software_irq_o
);

    logic [15:0]           off;
    logic [31:0]           wdata;
    decode_t               dec;
    logic                  rd;
    logic                  wr;
    logic [63:0]           mtime;
    logic [63:0]           cmp_arr [NUM_HARTS];
    logic [NUM_HARTS-1:0]  msip_vec;
    logic [31:0]           rd_word;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  unused_addr_hi;

    assign off            = bus.addr_i[15:0];
    assign unused_addr_hi = ^bus.addr_i[DATA_WIDTH-1:16];
    assign wdata          = bus.data_i[31:0];
    assign dec            = decode_addr(off, NUM_HARTS);
    assign rd             = (bus.req_i == CHIP_ENABLE) && !bus.we_i;
    assign wr             = (bus.req_i == CHIP_ENABLE) && bus.we_i;

    clint_mh_mtime #(
        .TICK_DIV (TICK_DIV)
    ) u_mtime (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stop_i  (mtime_stop_i),
        .wr_lo_i (wr && (dec.sel == REG_MTIME_LO)),
        .wr_hi_i (wr && (dec.sel == REG_MTIME_HI)),
        .wdata_i (wdata),
        .mtime_o (mtime)
    );

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        logic        hit;
        logic        msip_q, msip_d;
        logic [63:0] cmp_q, cmp_d;
        logic        irq_q, irq_d;

        assign hit = wr && (dec.hart == 4'(h));

        always_comb begin
            msip_d = msip_q;
            cmp_d  = cmp_q;
            if (hit) begin
                case (dec.sel)
                    REG_MSIP:   msip_d = wdata[0];
                    REG_CMP_LO: cmp_d  = {cmp_q[63:32], wdata};
                    REG_CMP_HI: cmp_d  = {wdata, cmp_q[31:0]};
                    default:    ;
                endcase
            end
            // Compares the registered mtime/mtimecmp, so the line follows the condition by one cycle.
            irq_d = (mtime >= cmp_q);
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i == RESET_ENABLE) begin
                msip_q <= 1'b0;
                cmp_q  <= MTIMECMP_RESET;
                irq_q  <= 1'b0;
            end else begin
                msip_q <= msip_d;
                cmp_q  <= cmp_d;
                irq_q  <= irq_d;
            end
        end

        assign cmp_arr[h]        = cmp_q;
        assign msip_vec[h]       = msip_q;
        assign timer_irq_o[h]    = irq_q;
        assign software_irq_o[h] = msip_q;
    end

    always_comb begin
        rd_word = ZERO;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (dec.hart == 4'(h)) begin
                case (dec.sel)
                    REG_MSIP:   rd_word = {31'b0, msip_vec[h]};
                    REG_CMP_LO: rd_word = cmp_arr[h][31:0];
                    REG_CMP_HI: rd_word = cmp_arr[h][63:32];
                    default:    ;
                endcase
            end
        end
        if (dec.sel == REG_MTIME_LO) begin
            rd_word = mtime[31:0];
        end else if (dec.sel == REG_MTIME_HI) begin
            rd_word = mtime[63:32];
        end
        rvalid_d = rd;
        rdata_d  = rd ? DATA_WIDTH'(rd_word) : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i == RESET_ENABLE) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.data_o   = rdata_q;
    assign bus.rvalid_o = rvalid_q;

endmodule

// File: tb/tb_clint_mh.sv
// Directed bench for clint_mh: one instance at TICK_DIV=1 and one at TICK_DIV=4 on a shared driver.
module tb_clint_mh;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stop = 1'b0;
    logic        sel = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [1:0]  tirq1, sirq1, tirq4, sirq4;
    int          cyc;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // Rising edges since reset release; the TICK_DIV=4 expectations derive from it.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    clint_mh_if #(.DATA_WIDTH(32)) bus1 ();
    clint_mh_if #(.DATA_WIDTH(32)) bus4 ();

    assign bus1.req_i  = req & ~sel;
    assign bus1.we_i   = we;
    assign bus1.addr_i = addr;
    assign bus1.data_i = wdata;
    assign bus4.req_i  = req & sel;
    assign bus4.we_i   = we;
    assign bus4.addr_i = addr;
    assign bus4.data_i = wdata;

    wire [31:0] rdata  = sel ? bus4.data_o : bus1.data_o;
    wire        rvalid = sel ? bus4.rvalid_o : bus1.rvalid_o;

    clint_mh #(.NUM_HARTS(2), .TICK_DIV(1), .DATA_WIDTH(32)) dut1 (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus1),
        .mtime_stop_i   (stop),
        .timer_irq_o    (tirq1),
        .software_irq_o (sirq1)
    );

    clint_mh #(.NUM_HARTS(2), .TICK_DIV(4), .DATA_WIDTH(32)) dut4 (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus4),
        .mtime_stop_i   (stop),
        .timer_irq_o    (tirq4),
        .software_irq_o (sirq4)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks start and end on a falling edge, so calls chain into consecutive cycles.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        check_eq("wr_no_rvalid", rvalid, 1'b0);
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        req = 1'b0;
        check_eq({tag, "_rvalid"}, rvalid, 1'b1);
        check_eq(tag, rdata, exp);
    endtask

    logic [31:0] b2b_addr [3];
    logic [31:0] exp_v;

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_rvalid1", bus1.rvalid_o, 1'b0);
        check_eq("rst_data1", bus1.data_o, 32'h0);
        check_eq("rst_rvalid4", bus4.rvalid_o, 1'b0);
        check_eq("rst_tirq", {tirq4, tirq1}, 4'b0);
        check_eq("rst_sirq", {sirq4, sirq1}, 4'b0);
        rst = 1'b0;

        read_check("cmp0_lo_rst", 32'h4000, 32'hFFFF_FFFF);
        read_check("cmp0_hi_rst", 32'h4004, 32'hFFFF_FFFF);
        read_check("msip0_rst", 32'h0000, 32'h0);
        check_eq("tirq_after_rst", tirq1, 2'b00);
        check_eq("sirq_after_rst", sirq1, 2'b00);

        // Prescaled mtime on the TICK_DIV=4 instance.
        sel = 1'b1;
        for (int i = 0; i < 200 && cyc < 40; i++) @(negedge clk);
        check_eq("reach_cyc40", cyc, 40);
        read_check("mtime_div4", 32'hBFF8, 32'd10);
        stop = 1'b1;
        exp_v = 32'(cyc / 4);
        repeat (20) @(negedge clk);
        read_check("mtime_stopped", 32'hBFF8, exp_v);
        read_check("mtime_hi_div4", 32'hBFFC, 32'h0);
        stop = 1'b0;

        // Carry across the halves and write-vs-tick priority at TICK_DIV=1.
        sel = 1'b0;
        bus_write(32'hBFF8, 32'hFFFF_FFFF);
        bus_write(32'hBFFC, 32'h0);
        repeat (2) @(negedge clk);
        read_check("carry_hi", 32'hBFFC, 32'd1);
        read_check("carry_lo", 32'hBFF8, 32'd2);
        bus_write(32'hBFF8, 32'h1234_5678);
        read_check("wr_tick_lo", 32'hBFF8, 32'h1234_5678);
        read_check("wr_tick_hi", 32'hBFFC, 32'd1);

        // Hart 1 timer interrupt around mtimecmp = 100.
        bus_write(32'hBFFC, 32'h0);
        bus_write(32'hBFF8, 32'h0);
        bus_write(32'h400C, 32'h0);
        bus_write(32'h4008, 32'd100);
        check_eq("tirq_armed", tirq1, 2'b00);
        read_check("cmp1_lo", 32'h4008, 32'd100);
        repeat (96) @(negedge clk);
        check_eq("tirq1_before", tirq1[1], 1'b0);
        repeat (2) @(negedge clk);
        check_eq("tirq1_after", tirq1[1], 1'b1);
        check_eq("tirq0_quiet", tirq1[0], 1'b0);
        bus_write(32'h4008, 32'hFFFF_FFFF);
        bus_write(32'h400C, 32'hFFFF_FFFF);
        check_eq("tirq1_cleared", tirq1, 2'b00);

        // Software interrupts and the absent hart 2.
        bus_write(32'h0004, 32'd3);
        check_eq("sirq_h1", sirq1, 2'b10);
        read_check("msip1", 32'h0004, 32'd1);
        bus_write(32'h0008, 32'd1);
        check_eq("sirq_h2_ignored", sirq1, 2'b10);
        read_check("msip2_absent", 32'h0008, 32'd0);
        read_check("msip0_still0", 32'h0000, 32'd0);

        // Back-to-back reads against a known mtime.
        bus_write(32'hBFFC, 32'h0);
        bus_write(32'hBFF8, 32'h500);
        b2b_addr[0] = 32'h0000;
        b2b_addr[1] = 32'hBFF8;
        b2b_addr[2] = 32'h1234;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h501);
        exp_q.push_back(32'h0);
        req = 1'b1; we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr = b2b_addr[i];
            @(negedge clk);
            check_eq("b2b_rvalid", rvalid, 1'b1);
            check_eq("b2b_data", rdata, exp_q.pop_front());
        end
        req = 1'b0;
        @(negedge clk);
        check_eq("b2b_idle_rvalid", rvalid, 1'b0);
        check_eq("b2b_idle_data", rdata, 32'h0);

        // Reset while a read result is on the bus.
        req = 1'b1; addr = 32'hBFF8;
        @(negedge clk);
        req = 1'b0;
        check_eq("pre_rst_rvalid", rvalid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_rvalid", rvalid, 1'b0);
        check_eq("async_rst_data", rdata, 32'h0);
        check_eq("async_rst_sirq", sirq1, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        read_check("cmp1_hi_rst", 32'h400C, 32'hFFFF_FFFF);
        read_check("mtime_hi_rst", 32'hBFFC, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
